tank_bullet_ctrl: RTL and testbench
===================================

Name: tank_bullet_ctrl

Overview:
- Projectile manager downstream of the tank movement stage.
- Consumes the tank's position, its current heading sin/cos and the shared USB keycode word; spawns up to NUM_BULLETS bullets along the tank's forward direction.
- Each frame it advances active bullets, reflects them off the screen edges, and retires them on lifetime expiry or a collision hit.
- Registered bullet positions and valid flags feed the sprite renderer and the collision logic.

Parameters:
- NUM_BULLETS, 4, number of bullet slots.
- FIRE_KEY, 8'h28, HID code that fires (Enter).
- BULLET_STEP, 7'd6, speed magnitude in pixels/frame at |sin| or |cos| = 127.
- LIFETIME, 9'd240, frames a bullet stays valid.
- COOLDOWN, 5'd15, frames after a successful fire during which firing is blocked.
- X_MIN/X_MAX, 0/639, horizontal bounds.
- Y_MIN/Y_MAX, 0/479, vertical bounds.

Ports:
- frame_clk, in, 1, frame-rate clock.
- Reset_n, in, 1, asynchronous active-low reset.
- keycode, in, 32, four HID key bytes; a key is pressed if any byte matches.
- TankX, in, 10, tank centre X.
- TankY, in, 10, tank centre Y.
- sin, in, 8, sign-magnitude heading sine: bit7 = sign, [6:0] = magnitude in units of 1/128.
- cos, in, 8, sign-magnitude heading cosine, same format as sin.
- hit_clear, in, NUM_BULLETS, per-slot retire request from collision logic.
- BulletX, out, 10*NUM_BULLETS, packed X positions; slot i occupies [10i+9:10i].
- BulletY, out, 10*NUM_BULLETS, packed Y positions.
- BulletValid, out, NUM_BULLETS, slot active.
- Fired, out, 1, one-frame pulse when a bullet spawns.

Behaviour:
- Clock and reset:
  - One clock, frame_clk; all state updates on its rising edge.
  - Reset is asynchronous and active-low on Reset_n.
  - Reset clears all positions, velocities, lifetimes, BulletValid, Fired, the cooldown counter and the key-history flop to 0.
  - Reset asserted mid-flight discards all bullets immediately.
- Fire detect:
  - pressed = any keycode byte == FIRE_KEY; key_prev <= pressed every frame.
  - A fire request is pressed & ~key_prev (rising edge only); holding the key fires once.
- Spawn, all conditions evaluated on the same edge:
  - Requires: fire request, cooldown == 0, and at least one slot free at the start of the frame.
  - Target is the lowest-index free slot.
  - That slot loads X = TankX, Y = TankY, life = LIFETIME, valid = 1, and velocity per the rule below.
  - On spawn: Fired = 1 for that frame only; cooldown <= COOLDOWN.
  - No free slot: the request is dropped, Fired = 0, cooldown is not started.
  - A request during cooldown is dropped.
  - Cooldown decrements by 1 each frame while nonzero.
- Velocity, latched at spawn and never recomputed from later sin/cos:
  - m = (BULLET_STEP * mag) >> 7, giving 7 bits, then zero-extended to 10-bit two's complement.
  - Forward direction is (+cos, -sin).
  - vx = +m_cos if cos[7] == 0, else -m_cos.
  - vy = -m_sin if sin[7] == 0, else +m_sin.
  - Magnitude 0 yields velocity 0 regardless of sign.
- Per active slot each frame, in priority order:
  1. hit_clear[i] = 1: valid <= 0. The slot is not considered free for a spawn in this same frame.
  2. life == 1: valid <= 0.
  3. Otherwise life <= life - 1 and the slot moves.
- Move rule, per axis independently:
  - nx = X + vx, evaluated as 11-bit signed.
  - If nx < X_MIN or nx > X_MAX: vx <= -vx and X holds.
  - Otherwise X <= nx. Y uses the same rule with vy.
- Timing:
  - A slot spawned this frame does not move until the next frame.
  - Latency from fire-key edge to BulletValid is 1 frame.
  - A bullet is valid for exactly LIFETIME frames and moves LIFETIME-1 times.
- Inactive slots hold their last X/Y; consumers must gate on BulletValid.

Test Plan:
- Reset:
  - Hold Reset_n = 0 with random inputs -> BulletValid = 0, Fired = 0, BulletX = BulletY = 0.
  - Release -> no spawn without a key edge.
- Spawn and move:
  - TankX = 300, TankY = 250, cos = 8'h7F, sin = 8'h00; keycode goes 0 -> 32'h00000028.
  - Next frame: slot0 valid at (300,250), Fired = 1.
  - Following frames: X = 305, 310 (vx = 762 >> 7 = 5), Y = 250, Fired = 0.
- Hold and cooldown:
  - Hold the key for 30 frames -> exactly one bullet.
  - Release, then re-press 5 frames after the spawn -> no spawn.
  - Re-press after 15+ frames -> slot1 valid, Fired pulses.
- Edge bounce:
  - sin = 8'h7F, cos = 8'h00, TankY = 12 -> vy = -5; Y = 12, 7, 2.
  - Next frame: 2 - 5 < 0 -> Y holds at 2, vy = +5.
  - Then Y = 7, 12.
- Lifetime:
  - LIFETIME = 240 -> BulletValid[0] high for exactly 240 consecutive frames, then 0.
  - The slot is reusable by the next fire.
- Slots full and hit:
  - Fire 4 times, spaced 16 frames apart -> slots 0-3 valid.
  - 5th fire -> dropped, Fired = 0, cooldown not started.
  - Pulse hit_clear = 4'b0100 -> slot2 invalid next frame.
  - Next fire -> slot2 respawns at the current TankX/TankY.

Source files
------------

// File: rtl/tank_bullet_ctrl_if.sv
// Bundles the tank-state inputs, the collision retire requests and the registered
// bullet outputs that connect the bullet manager to its neighbours.
interface tank_bullet_ctrl_if #(
  parameter int NUM_BULLETS = 4
);
  logic [31:0]               keycode;
  logic [9:0]                TankX;
  logic [9:0]                TankY;
  logic [7:0]                sin;
  logic [7:0]                cos;
  logic [NUM_BULLETS-1:0]    hit_clear;
  logic [10*NUM_BULLETS-1:0] BulletX;
  logic [10*NUM_BULLETS-1:0] BulletY;
  logic [NUM_BULLETS-1:0]    BulletValid;
  logic                      Fired;

  modport master (
    output keycode, TankX, TankY, sin, cos, hit_clear,
    input  BulletX, BulletY, BulletValid, Fired
  );

  modport slave (
    input  keycode, TankX, TankY, sin, cos, hit_clear,
    output BulletX, BulletY, BulletValid, Fired
  );
endinterface

// File: rtl/tank_bullet_ctrl.sv
// Bullet manager: edge-detected fire key spawns into the lowest free slot, each
// slot then advances once per frame, bounces off screen edges and retires.
module tank_bullet_slot #(
  parameter logic [8:0] LIFETIME = 9'd240,
  parameter int         X_MIN    = 0,
  parameter int         X_MAX    = 639,
  parameter int         Y_MIN    = 0,
  parameter int         Y_MAX    = 479
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spawn_i,
  input  logic       hit_i,
  input  logic [9:0] x0_i,
  input  logic [9:0] y0_i,
  input  logic [9:0] vx0_i,
  input  logic [9:0] vy0_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       valid_o
);
  localparam logic signed [10:0] XLO = 11'(X_MIN);
  localparam logic signed [10:0] XHI = 11'(X_MAX);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX);

  logic [9:0]        x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic [8:0]        life_q, life_d;
  logic              valid_q, valid_d;
  logic signed [10:0] nx, ny;

  always_comb begin
    nx      = $signed({1'b0, x_q}) + $signed({vx_q[9], vx_q});
    ny      = $signed({1'b0, y_q}) + $signed({vy_q[9], vy_q});
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    life_d  = life_q;
    valid_d = valid_q;
    if (spawn_i) begin
      x_d     = x0_i;
      y_d     = y0_i;
      vx_d    = vx0_i;
      vy_d    = vy0_i;
      life_d  = LIFETIME;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (hit_i || life_q == 9'd1) begin
        valid_d = 1'b0;
      end else begin
        life_d = life_q - 9'd1;
        // An out-of-range step reflects the velocity and leaves the position put.
        if (nx < XLO || nx > XHI) vx_d = -vx_q;
        else                      x_d  = nx[9:0];
        if (ny < YLO || ny > YHI) vy_d = -vy_q;
        else                      y_d  = ny[9:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      life_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      life_q  <= life_d;
      valid_q <= valid_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign valid_o = valid_q;
endmodule

module tank_bullet_ctrl #(
  parameter int         NUM_BULLETS = 4,
  parameter logic [7:0] FIRE_KEY    = 8'h28,
  parameter logic [6:0] BULLET_STEP = 7'd6,
  parameter logic [8:0] LIFETIME    = 9'd240,
  parameter logic [4:0] COOLDOWN    = 5'd15,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 479
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  tank_bullet_ctrl_if.slave      bif
);
  logic                         pressed, fire_req, spawn;
  logic                         key_prev_q, fired_q;
  logic [4:0]                   cd_q, cd_d;
  logic [NUM_BULLETS-1:0]       valid, free, sel_oh;
  logic [NUM_BULLETS-1:0][9:0]  bx, by;
  logic [9:0]                   m_cos, m_sin, vx0, vy0;

  function automatic logic [9:0] scale(input logic [6:0] mag);
    logic [13:0] p;
    p = 14'(BULLET_STEP) * 14'(mag);
    return {3'b000, p[13:7]};
  endfunction

  always_comb begin
    pressed = 1'b0;
    for (int b = 0; b < 4; b++)
      if (bif.keycode[8*b +: 8] == FIRE_KEY) pressed = 1'b1;
  end

  // Slots retired this frame are still valid here, so they cannot be reused yet.
  assign fire_req = pressed & ~key_prev_q;
  assign free     = ~valid;
  assign sel_oh   = free & (~free + 1'b1);
  assign spawn    = fire_req && (cd_q == 5'd0) && (|free);

  assign m_cos = scale(bif.cos[6:0]);
  assign m_sin = scale(bif.sin[6:0]);
  assign vx0   = bif.cos[7] ? -m_cos : m_cos;
  assign vy0   = bif.sin[7] ? m_sin : -m_sin;

  always_comb begin
    cd_d = cd_q;
    if (spawn)              cd_d = COOLDOWN;
    else if (cd_q != 5'd0)  cd_d = cd_q - 5'd1;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev_q <= 1'b0;
      fired_q    <= 1'b0;
      cd_q       <= '0;
    end else begin
      key_prev_q <= pressed;
      fired_q    <= spawn;
      cd_q       <= cd_d;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    tank_bullet_slot #(
      .LIFETIME(LIFETIME), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) u_slot (
      .clk_i   (frame_clk),
      .rst_ni  (Reset_n),
      .spawn_i (spawn & sel_oh[i]),
      .hit_i   (bif.hit_clear[i]),
      .x0_i    (bif.TankX),
      .y0_i    (bif.TankY),
      .vx0_i   (vx0),
      .vy0_i   (vy0),
      .x_o     (bx[i]),
      .y_o     (by[i]),
      .valid_o (valid[i])
    );
  end

  assign bif.BulletX     = bx;
  assign bif.BulletY     = by;
  assign bif.BulletValid = valid;
  assign bif.Fired       = fired_q;
endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// Directed scenarios for the bullet manager; expectations are queued with a target
// frame and a free-running monitor compares them against the DUT outputs.
module tb_tank_bullet_ctrl;
  localparam int SEL_VALID = 0, SEL_VBIT = 1, SEL_X = 2, SEL_Y = 3,
                 SEL_FIRED = 4, SEL_XALL = 5, SEL_YALL = 6;

  typedef struct {
    int          frame;
    int          sel;
    int          slot;
    logic [63:0] expv;
    string       name;
  } exp_t;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   fc        = 0;
  int   errors    = 0;
  int   checks    = 0;
  int   s0;
  exp_t q[$];
  int   fq[$];

  tank_bullet_ctrl_if #(.NUM_BULLETS(4)) bif ();

  tank_bullet_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bif       (bif)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) fc <= fc + 1;

  function automatic logic [63:0] sample(input int sel, input int s);
    case (sel)
      SEL_VALID: return 64'(bif.BulletValid);
      SEL_VBIT:  return 64'(bif.BulletValid[s]);
      SEL_X:     return 64'(bif.BulletX[10*s +: 10]);
      SEL_Y:     return 64'(bif.BulletY[10*s +: 10]);
      SEL_FIRED: return 64'(bif.Fired);
      SEL_XALL:  return 64'(bif.BulletX);
      default:   return 64'(bif.BulletY);
    endcase
  endfunction

  // Monitor: checks Fired pulses against expected spawn frames, then any queued samples.
  always @(negedge frame_clk) begin
    if (fq.size() > 0 && fq[0] < fc) begin
      checks++;
      errors++;
      $display("FAIL fire_missing frame=%0d got=0 exp=1", fq[0]);
      void'(fq.pop_front());
    end
    if (bif.Fired) begin
      checks++;
      if (fq.size() > 0 && fq[0] == fc) void'(fq.pop_front());
      else begin
        errors++;
        $display("FAIL fire_unexpected frame=%0d got=1 exp=0", fc);
      end
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].frame == fc) begin
        logic [63:0] got;
        got = sample(q[i].sel, q[i].slot);
        checks++;
        if (got !== q[i].expv) begin
          errors++;
          $display("FAIL %s frame=%0d got=%0h exp=%0h", q[i].name, fc, got, q[i].expv);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input int off, input int sel, input int slot, input logic [63:0] v,
                     input string nm);
    exp_t e;
    e.frame = fc + off;
    e.sel   = sel;
    e.slot  = slot;
    e.expv  = v;
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic expect_fire(input int off);
    fq.push_back(fc + off);
  endtask

  initial begin
    bif.hit_clear = '0;
    // Reset held with scrambled inputs (no byte can match the fire key).
    for (int r = 0; r < 3; r++) begin
      bif.keycode = $urandom & 32'h0707_0707;
      bif.TankX   = 10'($urandom);
      bif.TankY   = 10'($urandom);
      bif.sin     = 8'($urandom);
      bif.cos     = 8'($urandom);
      bif.hit_clear = 4'($urandom);
      tick(1);
      chk(0, SEL_VALID, 0, 64'h0, "rst_valid");
      chk(0, SEL_FIRED, 0, 64'h0, "rst_fired");
      chk(0, SEL_XALL,  0, 64'h0, "rst_x");
      chk(0, SEL_YALL,  0, 64'h0, "rst_y");
    end
    bif.keycode = 32'h0; bif.hit_clear = '0;
    bif.TankX = 10'd300; bif.TankY = 10'd250; bif.cos = 8'h7F; bif.sin = 8'h00;
    Reset_n = 1'b1;
    chk(1, SEL_VALID, 0, 64'h0, "idle_valid1");
    chk(3, SEL_VALID, 0, 64'h0, "idle_valid3");
    tick(3);

    // Spawn slot0, move +5/frame in X; later sin/cos changes must not alter it.
    bif.keycode = 32'h0000_0028;
    s0 = fc + 1;
    expect_fire(1);
    chk(1,   SEL_VALID, 0, 64'h1,   "s0_valid");
    chk(1,   SEL_X,     0, 64'd300, "s0_x0");
    chk(1,   SEL_Y,     0, 64'd250, "s0_y0");
    chk(2,   SEL_X,     0, 64'd305, "s0_x1");
    chk(3,   SEL_X,     0, 64'd310, "s0_x2");
    chk(3,   SEL_Y,     0, 64'd250, "s0_y2");
    chk(2,   SEL_FIRED, 0, 64'h0,   "s0_fired_off");
    chk(240, SEL_VBIT,  0, 64'h1,   "s0_life_last");
    chk(241, SEL_VBIT,  0, 64'h0,   "s0_life_expired");
    tick(1);
    bif.sin = 8'hFF; bif.cos = 8'h85;
    tick(29);
    bif.keycode = 32'h0;
    tick(1);

    // Slot1: cos magnitude 5 scales to 0 despite negative sign; vy = +5.
    bif.keycode = 32'h2800_0000;
    expect_fire(1);
    chk(1, SEL_VBIT, 1, 64'h1,   "s1_valid");
    chk(1, SEL_Y,    1, 64'd250, "s1_y0");
    chk(3, SEL_Y,    1, 64'd260, "s1_y2");
    chk(3, SEL_X,    1, 64'd300, "s1_x_zero_vel");
    tick(1);
    bif.keycode = 32'h0;
    tick(4);
    bif.keycode = 32'h0000_0028;   // 5 frames after spawn: still cooling down
    chk(1, SEL_VALID, 0, 64'h3, "cooldown_drop");
    tick(1);
    bif.keycode = 32'h0;
    tick(10);
    bif.keycode = 32'h0028_0000;   // 16 frames after spawn: allowed
    expect_fire(1);
    chk(1, SEL_VALID, 0, 64'h7,   "s2_valid");
    chk(1, SEL_X,     2, 64'd300, "s2_x0");
    chk(1, SEL_Y,     2, 64'd250, "s2_y0");
    tick(1);
    bif.keycode = 32'h0;
    tick(15);

    // Slot3 moves up from Y=12 and bounces at the top edge.
    bif.TankY = 10'd12; bif.sin = 8'h7F; bif.cos = 8'h00;
    bif.keycode = 32'h0000_2800;
    expect_fire(1);
    chk(1, SEL_VALID, 0, 64'hF,   "s3_all_valid");
    chk(1, SEL_Y,     3, 64'd12,  "bounce_y0");
    chk(2, SEL_Y,     3, 64'd7,   "bounce_y1");
    chk(3, SEL_Y,     3, 64'd2,   "bounce_y2");
    chk(4, SEL_Y,     3, 64'd2,   "bounce_hold");
    chk(5, SEL_Y,     3, 64'd7,   "bounce_y4");
    chk(6, SEL_Y,     3, 64'd12,  "bounce_y5");
    chk(6, SEL_X,     3, 64'd300, "bounce_x");
    tick(1);
    bif.keycode = 32'h0;
    tick(15);

    // All slots busy: request dropped, no cooldown started.
    bif.keycode = 32'h0000_0028;
    chk(1, SEL_VALID, 0, 64'hF, "full_drop");
    tick(1);
    bif.keycode = 32'h0;
    tick(1);
    // Hit and fire on the same edge: the hit slot is not yet free.
    bif.hit_clear = 4'b0100;
    bif.keycode   = 32'h0000_0028;
    chk(1, SEL_VALID, 0, 64'hB, "hit_clear");
    tick(1);
    bif.hit_clear = '0;
    bif.keycode   = 32'h0;
    tick(1);
    bif.TankX = 10'd100; bif.TankY = 10'd50;
    bif.keycode = 32'h0000_0028;
    expect_fire(1);
    chk(1, SEL_VALID, 0, 64'hF,   "respawn_valid");
    chk(1, SEL_X,     2, 64'd100, "respawn_x");
    chk(1, SEL_Y,     2, 64'd50,  "respawn_y");
    tick(1);
    bif.keycode = 32'h0;

    // Reuse slot0 once its lifetime has run out.
    while (fc < s0 + 240) tick(1);
    bif.keycode = 32'h0000_0028;
    expect_fire(1);
    chk(1, SEL_VBIT, 0, 64'h1,   "reuse_valid");
    chk(1, SEL_X,    0, 64'd100, "reuse_x");
    chk(1, SEL_Y,    0, 64'd50,  "reuse_y");
    chk(2, SEL_Y,    0, 64'd45,  "reuse_y1");
    tick(3);
    bif.keycode = 32'h0;

    // Asynchronous reset mid-flight.
    Reset_n = 1'b0;
    chk(0, SEL_VALID, 0, 64'h0, "midrst_valid");
    chk(0, SEL_XALL,  0, 64'h0, "midrst_x");
    chk(0, SEL_YALL,  0, 64'h0, "midrst_y");
    chk(0, SEL_FIRED, 0, 64'h0, "midrst_fired");
    tick(2);
    Reset_n = 1'b1;
    tick(2);

    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL pending_%s frame=%0d got=none exp=%0h", q[i].name, q[i].frame, q[i].expv);
    end
    foreach (fq[i]) begin
      checks++;
      errors++;
      $display("FAIL pending_fire frame=%0d got=0 exp=1", fq[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
